// File: rtl/cordic_rot_sequencer.sv
// Iterative CORDIC rotation-mode sequencer: arbitrates two requesters and runs one job
// through NUM_STAGES shift-add micro-rotations, returning the unscaled result with a requester tag.
module cordic_rot_sequencer #(
  parameter int CORDIC_WIDTH = 22,
  parameter int NUM_STAGES   = 16,
  localparam int CNT_W       = $clog2(NUM_STAGES) + 1
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [CORDIC_WIDTH-1:0] req0_x,
  input  logic [CORDIC_WIDTH-1:0] req0_y,
  input  logic [NUM_STAGES-1:0]   req0_dir,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [CORDIC_WIDTH-1:0] req1_x,
  input  logic [CORDIC_WIDTH-1:0] req1_y,
  input  logic [NUM_STAGES-1:0]   req1_dir,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CORDIC_WIDTH-1:0] x_out,
  output logic [CORDIC_WIDTH-1:0] y_out,
  output logic                    out_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CORDIC_WIDTH-1:0] x_r;
  logic [CORDIC_WIDTH-1:0] y_r;
  logic [NUM_STAGES-1:0]   dir_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    last_grant_r;
  logic                    grant_s;
  logic                    accept_s;
  logic                    last_stage_s;
  logic                    d_s;
  logic [CORDIC_WIDTH-1:0] x_sh_s;
  logic [CORDIC_WIDTH-1:0] y_sh_s;
  logic [CORDIC_WIDTH-1:0] x_nxt_s;
  logic [CORDIC_WIDTH-1:0] y_nxt_s;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // One micro-rotation from the pre-edge x/y; sums wrap at CORDIC_WIDTH.
  always_comb begin
    d_s          = dir_r[cnt_r[CNT_W-2:0]];
    x_sh_s       = $signed(x_r) >>> cnt_r;
    y_sh_s       = $signed(y_r) >>> cnt_r;
    last_stage_s = (cnt_r == CNT_W'(NUM_STAGES - 1));
    if (d_s) begin
      x_nxt_s = x_r - y_sh_s;
      y_nxt_s = y_r + x_sh_s;
    end else begin
      x_nxt_s = x_r + y_sh_s;
      y_nxt_s = y_r - x_sh_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s) state_nxt_s = ST_ROT;  else state_nxt_s = ST_IDLE;
      ST_ROT:  if (enable && last_stage_s) state_nxt_s = ST_DONE; else state_nxt_s = ST_ROT;
      ST_DONE: if (out_ready) state_nxt_s = ST_IDLE; else state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs; at most one ready since grant selects a single requester.
  always_comb begin
    req0_ready = (state_r == ST_IDLE) && !grant_s && req0_valid;
    req1_ready = (state_r == ST_IDLE) &&  grant_s && req1_valid;
    accept_s   = req0_ready || req1_ready;
    busy       = (state_r != ST_IDLE);
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_r          <= '0;
      y_r          <= '0;
      dir_r        <= '0;
      cnt_r        <= '0;
      last_grant_r <= 1'b1;
      out_valid    <= 1'b0;
      out_id       <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            x_r          <= grant_s ? req1_x   : req0_x;
            y_r          <= grant_s ? req1_y   : req0_y;
            dir_r        <= grant_s ? req1_dir : req0_dir;
            out_id       <= grant_s;
            last_grant_r <= grant_s;
            cnt_r        <= '0;
          end
        end
        ST_ROT: begin
          if (enable) begin
            x_r   <= x_nxt_s;
            y_r   <= y_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_stage_s) begin
              out_valid <= 1'b1;
              x_out     <= x_nxt_s;
              y_out     <= y_nxt_s;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
